// File: rtl/instruction_loader_pkg.sv
// Shared field widths and FSM state encoding for the instruction loader.
// The field-width macros take their values from parameters.v when it is compiled first; otherwise the defaults below apply.
`ifndef WIDTH_OPCODE
`define WIDTH_OPCODE 7
`endif
`ifndef REGFILE_ADDR_BITS
`define REGFILE_ADDR_BITS 5
`endif
`ifndef IMMEDIATE_WIDTH
`define IMMEDIATE_WIDTH 10
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH (`WIDTH_OPCODE + 3 * `REGFILE_ADDR_BITS + `IMMEDIATE_WIDTH)
`endif

package instruction_loader_pkg;
    localparam int OPCODE_W = `WIDTH_OPCODE;
    localparam int REG_W    = `REGFILE_ADDR_BITS;
    localparam int IMM_W    = `IMMEDIATE_WIDTH;
    localparam int INSTR_W  = `INSTRUCTION_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;
endpackage

// File: rtl/instruction_loader_if.sv
// Instruction field-set handshake between a producer (master) and the loader (slave).
interface instruction_loader_if;
    import instruction_loader_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    reg_dest;
    logic [REG_W-1:0]    reg_source_1;
    logic [REG_W-1:0]    reg_source_2;
    logic [IMM_W-1:0]    immediate;

    modport master (
        output in_valid, in_last, opcode, reg_dest, reg_source_1, reg_source_2, immediate,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, opcode, reg_dest, reg_source_1, reg_source_2, immediate,
        output in_ready
    );
endinterface

// File: rtl/instruction_loader.sv
// Packs instruction field sets into words and writes them to instruction memory from a base address.
// Define LOADER_CHECKSUM_EN to add a running XOR checksum of the words written in a session.
//
// state | meaning
// IDLE  | waiting for start; field sets ignored
// LOAD  | accepting one field set per cycle, writing the previous one
// DONE  | final write in flight; one cycle, then back to IDLE
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    instruction_loader_if.slave  ld,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [INSTR_W-1:0]   mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [ADDR_BITS:0]   word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [INSTR_W-1:0]   checksum
`endif
);

    loader_state_t        state_q;
    loader_state_t        state_d;
    logic [ADDR_BITS-1:0] ptr_q;
    logic                 accept;
    logic                 start_ok;
    logic                 ptr_at_top;
    logic [INSTR_W-1:0]   packed_word;

    // Exact inverse of the instruction register field split: opcode in the MSBs.
    assign packed_word = {ld.opcode, ld.reg_dest, ld.reg_source_1, ld.reg_source_2, ld.immediate};
    assign ptr_at_top  = &ptr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ld.in_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        start_ok    = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                ld.in_ready = 1'b1;
                busy        = 1'b1;
                accept      = ld.in_valid;
                // Writing the last address ends the session even without in_last.
                if (accept && (ld.in_last || ptr_at_top)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q      <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_we <= accept;
            if (start_ok) begin
                ptr_q      <= base_addr;
                word_count <= '0;
                overflow   <= 1'b0;
            end else if (accept) begin
                ptr_q      <= ptr_q + 1'b1;
                word_count <= word_count + 1'b1;
                mem_addr   <= ptr_q;
                mem_wdata  <= packed_word;
                if (ptr_at_top && !ld.in_last) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Folded in at accept, so it already covers the final word while that word is being written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum ^ packed_word;
        end
    end
`endif

endmodule
